// File: rtl/mac_pkg.sv
// Shared MAC definitions: default datapath widths and the requantize helper
// used by the MAC result path.
package mac_pkg;

    localparam int unsigned MAC_ACC_W     = 40;
    localparam int unsigned MAC_OP_W      = 16;
    localparam int unsigned MAC_FRAC_BITS = 8;

    // Widest word sat_shift handles; callers zero-extend into it, which leaves
    // room for the rounding carry as long as the accumulator is narrower.
    localparam int unsigned MAC_SS_W = 64;

    typedef struct packed {
        logic                sat;
        logic [MAC_SS_W-1:0] word;
    } sat_res_t;

    // Shift out the fractional bits (optionally round-half-up first) and clip
    // the result to out_width bits, flagging when clipping happened.
    function automatic sat_res_t sat_shift(
        input logic [MAC_SS_W-1:0] word,
        input int unsigned         frac_bits,
        input int unsigned         out_width,
        input logic                round_en
    );
        logic [MAC_SS_W-1:0] sum;
        logic [MAC_SS_W-1:0] q;
        logic [MAC_SS_W-1:0] max_v;
        sat_res_t            res;
        sum = word;
        if (round_en) begin
            sum = word + (MAC_SS_W'(1) << (frac_bits - 1));
        end
        q        = sum >> frac_bits;
        max_v    = (MAC_SS_W'(1) << out_width) - MAC_SS_W'(1);
        res.sat  = (q > max_v);
        res.word = res.sat ? max_v : q;
        return res;
    endfunction

endpackage

// File: rtl/mac_sync_fifo.sv
// Synchronous show-ahead FIFO with registered head word, count and flags.
// Pointers wrap naturally (DEPTH is a power of two); occupancy is a separate
// counter. A push into a full FIFO is accepted only when a pop happens in
// the same cycle.
module mac_sync_fifo #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 8
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       wdata,
    input  logic                   pop,
    output logic [WIDTH-1:0]       rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    rd_ptr_nxt;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_nxt;
    logic [WIDTH-1:0] rdata_q;
    logic [WIDTH-1:0] rdata_nxt;
    logic             full_q;
    logic             empty_q;
    logic             do_push;
    logic             do_pop;

    // Accepted push/pop, next occupancy and the word that will sit at the head.
    always_comb begin
        do_pop     = pop && !empty_q;
        do_push    = push && (!full_q || do_pop);
        rd_ptr_nxt = rd_ptr + AW'(do_pop);
        count_nxt  = count_q + CW'(do_push) - CW'(do_pop);
        rdata_nxt  = '0;
        if ((count_q - CW'(do_pop)) != '0) begin
            rdata_nxt = mem[rd_ptr_nxt];
        end else if (do_push) begin
            rdata_nxt = wdata;
        end
    end

    // Storage array, intentionally not reset.
    always_ff @(posedge i_clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers, occupancy and registered head/flag outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            rdata_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            rd_ptr  <= rd_ptr_nxt;
            count_q <= count_nxt;
            rdata_q <= rdata_nxt;
            full_q  <= (count_nxt == CW'(DEPTH));
            empty_q <= (count_nxt == '0);
        end
    end

    assign rdata = rdata_q;
    assign full  = full_q;
    assign empty = empty_q;
    assign count = count_q;

endmodule

// File: rtl/mac_result_sink.sv
// Receiving end of the MAC result stream: requantizes each accumulator word
// to operand width with saturation, buffers it, and hands it downstream over
// ready/valid. Dropped and clipped words raise sticky flags.
// Build option: define MAC_SINK_ROUND_EN for round-half-up before the shift
// (default is plain truncation).
module mac_result_sink
    import mac_pkg::*;
#(
    parameter int unsigned ACC_WIDTH = MAC_ACC_W,
    parameter int unsigned OUT_WIDTH = MAC_OP_W,
    parameter int unsigned FRAC_BITS = MAC_FRAC_BITS,
    parameter int unsigned DEPTH     = 8
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [ACC_WIDTH-1:0]   i_val,
    input  logic                   i_valid,
    output logic [OUT_WIDTH-1:0]   o_data,
    output logic                   o_valid,
    input  logic                   i_ready,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_overflow,
    output logic                   o_sat,
    input  logic                   i_clr_flags
);

`ifdef MAC_SINK_ROUND_EN
    localparam logic ROUND_EN = 1'b1;
`else
    localparam logic ROUND_EN = 1'b0;
`endif

    sat_res_t       q_res_c;
    logic           unused_q_hi;
    logic           q_valid;
    logic           q_sat;
    logic [OUT_WIDTH-1:0] q_word;
    logic           fifo_full;
    logic           fifo_empty;
    logic           pop_c;
    logic           ovf_evt_c;
    logic           sat_evt_c;
    logic           overflow_q;
    logic           sat_q;

    // Requantize the incoming word; upper bits are zero after clipping.
    always_comb begin
        q_res_c = sat_shift(MAC_SS_W'(i_val), FRAC_BITS, OUT_WIDTH, ROUND_EN);
    end

    assign unused_q_hi = ^q_res_c.word[MAC_SS_W-1:OUT_WIDTH];

    // Quantize stage register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            q_valid <= 1'b0;
            q_word  <= '0;
            q_sat   <= 1'b0;
        end else begin
            q_valid <= i_valid;
            if (i_valid) begin
                q_word <= q_res_c.word[OUT_WIDTH-1:0];
                q_sat  <= q_res_c.sat;
            end
        end
    end

    // Pop on handshake; a full FIFO without a pop drops the staged word.
    always_comb begin
        pop_c     = !fifo_empty && i_ready;
        ovf_evt_c = q_valid && fifo_full && !pop_c;
        sat_evt_c = q_valid && q_sat && (!fifo_full || pop_c);
    end

    mac_sync_fifo #(
        .WIDTH (OUT_WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .push  (q_valid),
        .wdata (q_word),
        .pop   (pop_c),
        .rdata (o_data),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (o_count)
    );

    // Sticky status flags; a set event beats a clear in the same cycle.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            overflow_q <= 1'b0;
            sat_q      <= 1'b0;
        end else begin
            if (i_clr_flags) begin
                overflow_q <= 1'b0;
                sat_q      <= 1'b0;
            end
            if (ovf_evt_c) begin
                overflow_q <= 1'b1;
            end
            if (sat_evt_c) begin
                sat_q <= 1'b1;
            end
        end
    end

    assign o_valid    = !fifo_empty;
    assign o_overflow = overflow_q;
    assign o_sat      = sat_q;

endmodule

// File: tb/tb_mac_result_sink.sv
// Scoreboard bench for mac_result_sink (DEPTH=4). Expected words are queued
// when stimulus is driven and compared on every output handshake.
module tb_mac_result_sink;

    localparam int unsigned ACC_W = 40;
    localparam int unsigned OUT_W = 16;
    localparam int unsigned DEP   = 4;

    logic             clk;
    logic             rst;
    logic [ACC_W-1:0] val;
    logic             valid;
    logic [OUT_W-1:0] data;
    logic             ovalid;
    logic             ready;
    logic [2:0]       count;
    logic             ovf;
    logic             sat;
    logic             clr;

    int n_checks = 0;
    int n_pass   = 0;
    logic [OUT_W-1:0] sb[$];

    mac_result_sink #(
        .ACC_WIDTH (ACC_W),
        .OUT_WIDTH (OUT_W),
        .FRAC_BITS (8),
        .DEPTH     (DEP)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_val       (val),
        .i_valid     (valid),
        .o_data      (data),
        .o_valid     (ovalid),
        .i_ready     (ready),
        .o_count     (count),
        .o_overflow  (ovf),
        .o_sat       (sat),
        .i_clr_flags (clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Reference requantizer: {sat, word}.
    function automatic logic [16:0] model_q(input logic [ACC_W-1:0] v);
        logic [63:0] s;
        s = 64'(v);
`ifdef MAC_SINK_ROUND_EN
        s = s + 64'd128;
`endif
        s = s >> 8;
        if (s > 64'h0000_0000_0000_FFFF) begin
            return {1'b1, 16'hFFFF};
        end
        return {1'b0, s[15:0]};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one word for one cycle; queue its expected value unless it will be dropped.
    task automatic send(input logic [ACC_W-1:0] v, input bit keep);
        logic [16:0] m;
        m     = model_q(v);
        valid = 1'b1;
        val   = v;
        if (keep) sb.push_back(m[15:0]);
        step();
        valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        ready = 1'b1;
        for (int i = 0; i < 64 && (sb.size() != 0 || ovalid); i++) step();
        @(negedge clk);
        check({tag, "_sb_empty"}, 64'(sb.size()), 64'd0);
        check({tag, "_count0"}, 64'(count), 64'd0);
    endtask

    // Output monitor: compare each accepted word against the scoreboard.
    always @(negedge clk) begin
        if (!rst && ovalid && ready) begin
            if (sb.size() == 0) begin
                check("unexpected_word", 64'(data), 64'hDEAD_BEEF);
            end else begin
                check("stream_data", 64'(data), 64'(sb.pop_front()));
            end
        end
    end

    initial begin
        logic [ACC_W-1:0] v;
        logic [16:0]      m;
        int               sent;
        clk   = 1'b0;
        rst   = 1'b1;
        val   = '0;
        valid = 1'b0;
        ready = 1'b0;
        clr   = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        @(negedge clk);
        check("rst_valid", 64'(ovalid), 64'd0);
        check("rst_count", 64'(count), 64'd0);
        check("rst_ovf", 64'(ovf), 64'd0);
        check("rst_sat", 64'(sat), 64'd0);
        check("rst_data", 64'(data), 64'd0);

        // Truncate / round path and two-cycle latency.
        step();
        ready = 1'b1;
`ifdef MAC_SINK_ROUND_EN
        v = 40'h00_0001_2380;
        m = 17'h0_0124;
`else
        v = 40'h00_0001_2345;
        m = 17'h0_0123;
`endif
        send(v, 1'b1);
        @(negedge clk);
        check("lat_n1_valid", 64'(ovalid), 64'd0);
        step();
        @(negedge clk);
        check("lat_n2_valid", 64'(ovalid), 64'd1);
        check("lat_n2_data", 64'(data), 64'(m[15:0]));
        check("lat_sat", 64'(sat), 64'd0);

        // Exactly at max after truncation; clipped only when rounding.
        v = 40'h00_00FF_FF80;
        m = model_q(v);
        send(v, 1'b1);
        step();
        @(negedge clk);
        check("edge_sat", 64'(sat), 64'(m[16]));
        step();
        clr = 1'b1;
        step();
        clr = 1'b0;
        @(negedge clk);
        check("clr_sat", 64'(sat), 64'd0);

        // Clear coincides with the saturating push: set wins.
        send(40'h00_0100_0000, 1'b1);
        clr = 1'b1;
        step();
        clr = 1'b0;
        @(negedge clk);
        check("sat_set_wins", 64'(sat), 64'd1);
        repeat (3) step();
        @(negedge clk);
        check("sat_sticky", 64'(sat), 64'd1);
        step();
        clr = 1'b1;
        step();
        clr = 1'b0;
        @(negedge clk);
        check("sat_cleared", 64'(sat), 64'd0);
        drain("dir");

        // Overflow: fill with 1..4, word 5 is dropped.
        step();
        ready = 1'b0;
        for (int i = 1; i <= 5; i++) send(40'(i) << 8, i <= 4);
        step();
        step();
        @(negedge clk);
        check("ovf_count", 64'(count), 64'd4);
        check("ovf_flag", 64'(ovf), 64'd1);
        check("ovf_nosat", 64'(sat), 64'd0);
        step();
        clr = 1'b1;
        step();
        clr = 1'b0;
        @(negedge clk);
        check("ovf_cleared", 64'(ovf), 64'd0);

        // Full with simultaneous push and pop.
        step();
        send(40'h6 << 8, 1'b1);
        ready = 1'b1;
        step();
        ready = 1'b0;
        @(negedge clk);
        check("fullpp_count", 64'(count), 64'd4);
        check("fullpp_ovf", 64'(ovf), 64'd0);
        step();
        ready = 1'b1;
        repeat (4) step();
        @(negedge clk);
        check("fullpp_nogap", 64'(count), 64'd0);
        check("fullpp_sb", 64'(sb.size()), 64'd0);

        // Random stream, throttled so outstanding words never exceed DEPTH.
        step();
        clr = 1'b1;
        step();
        clr = 1'b0;
        sent = 0;
        for (int cyc = 0; cyc < 4000 && sent < 100; cyc++) begin
            ready = 1'($urandom_range(0, 1));
            if (sb.size() < DEP && $urandom_range(0, 2) != 0) begin
                v = {8'($urandom), 32'($urandom)} >> $urandom_range(8, 24);
                m = model_q(v);
                sb.push_back(m[15:0]);
                val   = v;
                valid = 1'b1;
                sent++;
            end else begin
                valid = 1'b0;
            end
            step();
        end
        valid = 1'b0;
        check("stream_sent", 64'(sent), 64'd100);
        drain("stream");
        check("stream_ovf", 64'(ovf), 64'd0);

        // Reset with three words buffered and one in the quantize stage.
        ready = 1'b0;
        for (int i = 0; i < 4; i++) send(40'(i + 9) << 8, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        check("mrst_valid", 64'(ovalid), 64'd0);
        check("mrst_count", 64'(count), 64'd0);
        check("mrst_ovf", 64'(ovf), 64'd0);
        check("mrst_sat", 64'(sat), 64'd0);
        step();
        ready = 1'b1;
        send(40'h00_0000_AB00, 1'b1);
        send(40'h00_0000_CD00, 1'b1);
        drain("post_rst");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
